pipe_hazard_ctrl: RTL and testbench

//  Sequences the 5-stage RISC-V pipeline around the shared register file / data memory.

---
 rtl/riscv_pipe_pkg.sv | 20 ++
 rtl/pipe_hazard_ctrl_if.sv | 53 +++++
 rtl/hazard_perf_cnt.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 120 ++++++++++++
 5 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the RISC-V pipeline hazard controller.
package riscv_pipe_pkg;

    localparam int unsigned REG_AW_DEFAULT = 5;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: stage status in, stall/flush out.
// Performance counter signals exist only when HAZARD_PERF_EN is defined.
interface pipe_hazard_ctrl_if
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEFAULT,
    parameter int unsigned PERF_W = 32
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_memread;
    logic              ex_redirect;
    logic              mem_req;
    logic              dmem_ready;

    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
    logic memwb_bubble;
    logic mem_err;
`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;
    logic [PERF_W-1:0] lu_cnt;
`endif

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
               ex_redirect, mem_req, dmem_ready,
        input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, memwb_bubble, mem_err
`ifdef HAZARD_PERF_EN
        , input stall_cnt, flush_cnt, lu_cnt
`endif
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
               ex_redirect, mem_req, dmem_ready,
        output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, memwb_bubble, mem_err
`ifdef HAZARD_PERF_EN
        , output stall_cnt, flush_cnt, lu_cnt
`endif
    );

endinterface

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter used for hazard statistics.
module hazard_perf_cnt #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);
    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc_i && !(&cnt_q)) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: memory freeze with timeout, redirect flush,
// load-use bubble. Define HAZARD_PERF_EN to add saturating hazard counters.
module pipe_hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned REG_AW      = REG_AW_DEFAULT,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TO_W        = 8,
    parameter int unsigned PERF_W      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  hz
);
    if (MEM_TIMEOUT < 1 || (MEM_TIMEOUT >> TO_W) != 0) begin : g_bad_timeout
        $error("MEM_TIMEOUT must lie in 1..2^TO_W-1");
    end
    if (PERF_W == 0) begin : g_bad_perf_w
        $error("PERF_W must be nonzero");
    end

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

    hz_state_t         state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0]   cnt_inc;
    logic              mem_err_q, mem_err_d;
    logic              freeze;
    logic              timeout;
    logic              redirect;
    logic              load_use;
    logic              rs_match;
    logic [REG_AW-1:0] ex_rd;

    assign ex_rd   = hz.ex_rd;
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + TO_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    // The timeout cycle releases the freeze so the abandoned access drains as a bubble.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_err_d = mem_err_q;
        freeze    = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            RUN: begin
                cnt_d = '0;
                if (hz.mem_req && !hz.dmem_ready) begin
                    freeze  = 1'b1;
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (hz.dmem_ready) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_inc == TO_LIM) begin
                    timeout   = 1'b1;
                    mem_err_d = 1'b1;
                    state_d   = RUN;
                    cnt_d     = '0;
                end else begin
                    freeze = 1'b1;
                    cnt_d  = cnt_inc;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Outputs are gated by rst_n so an asserted reset silences them immediately.
    always_comb begin
        rs_match = (hz.id_use_rs1 && (hz.id_rs1 == ex_rd)) ||
                   (hz.id_use_rs2 && (hz.id_rs2 == ex_rd));
        redirect = rst_n && !freeze && hz.ex_redirect;
        load_use = rst_n && !freeze && !hz.ex_redirect && hz.ex_memread &&
                   (ex_rd != '0) && rs_match;
    end

    assign hz.pc_stall     = (rst_n && freeze) || load_use;
    assign hz.ifid_stall   = (rst_n && freeze) || load_use;
    assign hz.ifid_flush   = redirect;
    assign hz.idex_stall   = rst_n && freeze;
    assign hz.idex_flush   = redirect || load_use;
    assign hz.exmem_stall  = rst_n && freeze;
    assign hz.memwb_bubble = rst_n && (freeze || timeout);
    assign hz.mem_err      = mem_err_q;

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt #(.WIDTH(PERF_W)) u_stall_cnt (
        .clk(clk), .rst_n(rst_n), .inc_i(rst_n && freeze), .cnt_o(hz.stall_cnt)
    );
    hazard_perf_cnt #(.WIDTH(PERF_W)) u_flush_cnt (
        .clk(clk), .rst_n(rst_n), .inc_i(redirect), .cnt_o(hz.flush_cnt)
    );
    hazard_perf_cnt #(.WIDTH(PERF_W)) u_lu_cnt (
        .clk(clk), .rst_n(rst_n), .inc_i(load_use), .cnt_o(hz.lu_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT overridden to 4).
module tb_pipe_hazard_ctrl;
    logic clk;
    logic rst_n;
    int unsigned passed;
    int unsigned total;
    logic [7:0] outs;

    pipe_hazard_ctrl_if #(.REG_AW(5), .PERF_W(32)) hz ();

    pipe_hazard_ctrl #(
        .REG_AW(5), .MEM_TIMEOUT(4), .TO_W(8), .PERF_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hz(hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_bubble, mem_err}
    assign outs = {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_stall,
                   hz.idex_flush, hz.exmem_stall, hz.memwb_bubble, hz.mem_err};

    task automatic drive(input logic mrd, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic u1, input logic [4:0] rs2, input logic u2,
                         input logic redir, input logic mreq, input logic rdy);
        hz.ex_memread  = mrd;
        hz.ex_rd       = rd;
        hz.id_rs1      = rs1;
        hz.id_use_rs1  = u1;
        hz.id_rs2      = rs2;
        hz.id_use_rs2  = u2;
        hz.ex_redirect = redir;
        hz.mem_req     = mreq;
        hz.dmem_ready  = rdy;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        total++;
        assert (outs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, outs, exp);
    endtask

    task automatic chkp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Inputs change on the falling edge; checks follow 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("reset_outputs", 8'h00);
        step(); step();
        rst_n = 1'b1;

        // Load-use hazards
        drive(1, 5, 5, 1, 0, 0, 0, 0, 0); #1; chk("lu_rs1", 8'hC8);
        step(); drive(0, 5, 5, 1, 0, 0, 0, 0, 0); #1; chk("lu_one_bubble", 8'h00);
        step(); drive(1, 7, 0, 0, 7, 1, 0, 0, 0); #1; chk("lu_rs2", 8'hC8);
        step(); drive(1, 5, 5, 0, 5, 0, 0, 0, 0); #1; chk("lu_unused_src", 8'h00);
        step(); drive(1, 5, 6, 1, 7, 1, 0, 0, 0); #1; chk("lu_no_match", 8'h00);
        step(); drive(1, 0, 0, 1, 0, 1, 0, 0, 0); #1; chk("lu_x0", 8'h00);

        // Redirect overrides load-use
        step(); drive(1, 5, 5, 1, 0, 0, 1, 0, 0); #1; chk("redirect_over_lu", 8'h28);

        // Memory wait: three frozen cycles, redirect deferred to the release cycle
        step(); drive(0, 0, 0, 0, 0, 0, 0, 1, 0); #1; chk("miss_run", 8'hD6);
        step(); drive(0, 0, 0, 0, 0, 0, 1, 1, 0); #1; chk("wait1_redir_held", 8'hD6);
        step(); #1; chk("wait2", 8'hD6);
        step(); hz.dmem_ready = 1'b1; #1; chk("release_redirect", 8'h28);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1; chk("back_run_idle", 8'h00);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 1, 1); #1; chk("hit_no_freeze", 8'h00);

        // Timeout after 4 MEM_WAIT cycles
        step(); drive(0, 0, 0, 0, 0, 0, 0, 1, 0); #1; chk("to_miss_run", 8'hD6);
        step(); #1; chk("to_wait1", 8'hD6);
        step(); #1; chk("to_wait2", 8'hD6);
        step(); #1; chk("to_wait3", 8'hD6);
        step(); #1; chk("to_wait4_abandon", 8'h02);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1; chk("mem_err_set", 8'h01);
        step(); #1; chk("mem_err_sticky", 8'h01);
        step(); drive(1, 3, 3, 1, 0, 0, 0, 0, 0); #1; chk("lu_with_err", 8'hC9);

        // Async reset while in MEM_WAIT
        step(); drive(0, 0, 0, 0, 0, 0, 0, 1, 0); #1; chk("pre_rst_miss", 8'hD7);
        step(); #1; chk("pre_rst_wait", 8'hD7);
        #2; rst_n = 1'b0; #1; chk("async_rst_outputs", 8'h00);
        drive(1, 5, 5, 1, 0, 0, 1, 1, 0); #1; chk("rst_gates_inputs", 8'h00);
`ifdef HAZARD_PERF_EN
        chkp("rst_stall_cnt", hz.stall_cnt, 0);
        chkp("rst_flush_cnt", hz.flush_cnt, 0);
        chkp("rst_lu_cnt", hz.lu_cnt, 0);
`endif
        step(); rst_n = 1'b1; drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1; chk("post_rst_idle", 8'h00);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 1, 0); #1; chk("post_rst_miss", 8'hD6);
        step(); hz.dmem_ready = 1'b1; #1; chk("post_rst_release", 8'h00);
        step(); drive(0, 0, 0, 0, 0, 0, 1, 0, 0); #1; chk("post_rst_redirect", 8'h28);
        step(); drive(1, 9, 0, 0, 9, 1, 0, 0, 0); #1; chk("post_rst_lu", 8'hC8);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1; chk("final_idle", 8'h00);
`ifdef HAZARD_PERF_EN
        chkp("perf_stall_cnt", hz.stall_cnt, 1);
        chkp("perf_flush_cnt", hz.flush_cnt, 1);
        chkp("perf_lu_cnt", hz.lu_cnt, 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
